// File: rtl/xmmfifo_pkg.sv
// Shared definitions for the memory-mapped TX/RX FIFO block: bus widths,
// register offsets, STATUS flag positions and CTRL bit positions.
package xmmfifo_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_TXDATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RXDATA = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd3;

  // Flag positions relative to the end of the two count fields (2*CNT_W).
  localparam int unsigned ST_TX_EMPTY = 0;
  localparam int unsigned ST_TX_FULL  = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_UDF   = 5;

  localparam int unsigned CTRL_FLUSH_TX = 0;
  localparam int unsigned CTRL_FLUSH_RX = 1;
  localparam int unsigned CTRL_CLR_FLG  = 2;

endpackage

// File: rtl/xfifo_core.sv
// Synchronous FIFO with flush; head output reads 0 while empty so the
// consumer-facing data is defined after reset without clearing storage.
module xfifo_core
  import xmmfifo_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned CntW  = $clog2(Depth) + 1,
  parameter int unsigned Width = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [Width-1:0] i_din,
  output logic [Width-1:0] o_dout,
  output logic [CntW-1:0]  o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CntW'(Depth));

  // Flush dominates any concurrent transfer; illegal ops are filtered here too.
  assign w_do_push = i_push & ~w_full & ~i_flush;
  assign w_do_pop  = i_pop & ~w_empty & ~i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/xmmfifo.sv
// Processor-mapped TX/RX FIFO pair: CPU pushes TX / pops RX over a
// zero-wait-state bus, external side uses valid/ready handshakes.
module xmmfifo
  import xmmfifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  logic w_bus_wr;
  logic w_bus_rd;
  logic w_txdata_wr;
  logic w_ctrl_wr;
  logic w_rxdata_rd;

  logic w_tx_push;
  logic w_tx_pop;
  logic w_tx_flush;
  logic w_rx_push;
  logic w_rx_pop;
  logic w_rx_flush;
  logic w_clr_flags;
  logic w_tx_ovf_evt;
  logic w_rx_udf_evt;

  logic [DATA_W-1:0] w_tx_dout;
  logic [DATA_W-1:0] w_rx_dout;
  logic [CNT_W-1:0]  w_tx_count;
  logic [CNT_W-1:0]  w_rx_count;
  logic              w_tx_empty;
  logic              w_tx_full;
  logic              w_rx_empty;
  logic              w_rx_full;
  logic [DATA_W-1:0] w_status;

  logic r_tx_ovf;
  logic r_rx_udf;

  assign w_bus_wr    = sel & we;
  assign w_bus_rd    = sel & ~we;
  assign w_txdata_wr = w_bus_wr & (addr == ADDR_TXDATA);
  assign w_ctrl_wr   = w_bus_wr & (addr == ADDR_CTRL);
  assign w_rxdata_rd = w_bus_rd & (addr == ADDR_RXDATA);

  assign w_tx_flush  = w_ctrl_wr & data_in[CTRL_FLUSH_TX];
  assign w_rx_flush  = w_ctrl_wr & data_in[CTRL_FLUSH_RX];
  assign w_clr_flags = w_ctrl_wr & data_in[CTRL_CLR_FLG];

  // A full TX drops the write even if the consumer frees a slot this cycle.
  assign w_tx_push    = w_txdata_wr & ~w_tx_full;
  assign w_tx_ovf_evt = w_txdata_wr & w_tx_full;
  assign w_tx_pop     = tx_valid & tx_ready;

  assign w_rx_push    = rx_valid & rx_ready;
  assign w_rx_pop     = w_rxdata_rd & ~w_rx_empty;
  assign w_rx_udf_evt = w_rxdata_rd & w_rx_empty;

  xfifo_core #(
    .Depth (FIFO_DEPTH),
    .CntW  (CNT_W),
    .Width (DATA_W)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_flush (w_tx_flush),
    .i_din   (data_in),
    .o_dout  (w_tx_dout),
    .o_count (w_tx_count),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  xfifo_core #(
    .Depth (FIFO_DEPTH),
    .CntW  (CNT_W),
    .Width (DATA_W)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_flush (w_rx_flush),
    .i_din   (rx_data),
    .o_dout  (w_rx_dout),
    .o_count (w_rx_count),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      r_tx_ovf <= w_tx_ovf_evt | (r_tx_ovf & ~w_clr_flags);
      r_rx_udf <= w_rx_udf_evt | (r_rx_udf & ~w_clr_flags);
    end
  end

  always_comb begin
    w_status                            = '0;
    w_status[CNT_W-1:0]                 = w_tx_count;
    w_status[2*CNT_W-1:CNT_W]           = w_rx_count;
    w_status[2*CNT_W + ST_TX_EMPTY]     = w_tx_empty;
    w_status[2*CNT_W + ST_TX_FULL]      = w_tx_full;
    w_status[2*CNT_W + ST_RX_EMPTY]     = w_rx_empty;
    w_status[2*CNT_W + ST_RX_FULL]      = w_rx_full;
    w_status[2*CNT_W + ST_TX_OVF]       = r_tx_ovf;
    w_status[2*CNT_W + ST_RX_UDF]       = r_rx_udf;
  end

  always_comb begin
    data_out = '0;
    if (w_bus_rd) begin
      case (addr)
        ADDR_RXDATA: data_out = w_rx_dout;
        ADDR_STATUS: data_out = w_status;
        default:     data_out = '0;
      endcase
    end
  end

  assign tx_data  = w_tx_dout;
  assign tx_valid = ~w_tx_empty;
  assign rx_ready = ~w_rx_full;

endmodule

// File: tb/tb_xmmfifo.sv
// Self-checking bench for xmmfifo: queue scoreboards model both FIFOs and
// sticky flags; every cycle compares handshakes, heads and bus read data.
module tb_xmmfifo;
  import xmmfifo_pkg::*;

  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel, we;
  logic [1:0]  addr;
  logic [31:0] data_in, data_out, tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit          m_tx_ovf, m_rx_udf;
  logic [31:0] last_rd, last_tx;

  xmmfifo #(
    .FIFO_DEPTH (8),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int t = txq.size();
    int r = rxq.size();
    logic [31:0] s;
    s = 32'(t) + 32'(r) * 16;
    if (t == 0)     s |= 32'h0100;
    if (t == Depth) s |= 32'h0200;
    if (r == 0)     s |= 32'h0400;
    if (r == Depth) s |= 32'h0800;
    if (m_tx_ovf)   s |= 32'h1000;
    if (m_rx_udf)   s |= 32'h2000;
    return s;
  endfunction

  task automatic bus_idle();
    sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = '0;
  endtask

  // One clock with the currently driven inputs: check at negedge, then model the edge.
  task automatic step();
    logic [31:0] exp;
    bit tx_wr, rx_rd, ctrl_wr, tx_full0, rx_full0, rx_empty0, pop_tx;
    @(negedge clk);
    last_rd = data_out;
    last_tx = tx_data;
    check_eq("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
    check_eq("rx_ready", 32'(rx_ready), 32'(rxq.size() < Depth));
    if (txq.size() != 0) check_eq("tx_data", tx_data, txq[0]);
    else check_eq("tx_data_empty", tx_data, 32'h0);
    if (sel && !we) begin
      case (addr)
        2'd1:    exp = (rxq.size() != 0) ? rxq[0] : 32'h0;
        2'd2:    exp = exp_status();
        default: exp = 32'h0;
      endcase
      check_eq("data_out", data_out, exp);
    end else begin
      check_eq("data_out_idle", data_out, 32'h0);
    end
    tx_wr     = sel && we && addr == 2'd0;
    ctrl_wr   = sel && we && addr == 2'd3;
    rx_rd     = sel && !we && addr == 2'd1;
    tx_full0  = txq.size() == Depth;
    rx_full0  = rxq.size() == Depth;
    rx_empty0 = rxq.size() == 0;
    pop_tx    = txq.size() != 0 && tx_ready;
    if (ctrl_wr && data_in[0]) txq.delete();
    else begin
      if (pop_tx) void'(txq.pop_front());
      if (tx_wr && !tx_full0) txq.push_back(data_in);
    end
    if (ctrl_wr && data_in[1]) rxq.delete();
    else begin
      if (rx_rd && !rx_empty0) void'(rxq.pop_front());
      if (rx_valid && !rx_full0) rxq.push_back(rx_data);
    end
    m_tx_ovf = (tx_wr && tx_full0) || (m_tx_ovf && !(ctrl_wr && data_in[2]));
    m_rx_udf = (rx_rd && rx_empty0) || (m_rx_udf && !(ctrl_wr && data_in[2]));
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    step();
    bus_idle();
  endtask

  task automatic cpu_read(input logic [1:0] a);
    sel = 1'b1; we = 1'b0; addr = a; data_in = '0;
    step();
    bus_idle();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'h1);
    check_eq("rst_tx_data", tx_data, 32'h0);
    txq.delete(); rxq.delete();
    m_tx_ovf = 0; m_rx_udf = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check_eq("reset_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("reset_rx_ready", 32'(rx_ready), 32'h1);
    cpu_read(2'd2);
    check_eq("reset_status", last_rd, 32'h0000_0500);

    // Three TX words, then drain on consecutive cycles
    cpu_write(2'd0, 32'h11);
    cpu_write(2'd0, 32'h22);
    cpu_write(2'd0, 32'h33);
    tx_ready = 1'b1;
    step(); check_eq("tx_order0", last_tx, 32'h11);
    step(); check_eq("tx_order1", last_tx, 32'h22);
    step(); check_eq("tx_order2", last_tx, 32'h33);
    check_eq("tx_valid_fall", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Overflow: ninth word dropped
    for (int i = 0; i < 9; i++) cpu_write(2'd0, 32'h100 + 32'(i));
    cpu_read(2'd2);
    check_eq("tx_full_status", last_rd, 32'h0000_1608);
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    tx_ready = 1'b0;
    check_eq("tx_drained", 32'(tx_valid), 32'h0);

    // RX path, underflow and sticky clear
    rx_valid = 1'b1; rx_data = 32'hA5; step();
    rx_data = 32'h5A; step();
    rx_valid = 1'b0;
    cpu_read(2'd1); check_eq("rx_rd0", last_rd, 32'hA5);
    cpu_read(2'd1); check_eq("rx_rd1", last_rd, 32'h5A);
    cpu_read(2'd1); check_eq("rx_rd_empty", last_rd, 32'h0);
    cpu_read(2'd2); check_eq("rx_udf_set", last_rd, 32'h0000_3500);
    cpu_write(2'd3, 32'h4);
    cpu_read(2'd2); check_eq("flags_cleared", last_rd, 32'h0000_0500);

    // RX full: pop and offered word in the same cycle
    rx_valid = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      rx_data = 32'h200 + 32'(i);
      step();
    end
    rx_data = 32'h2FF;
    cpu_read(2'd1);
    check_eq("rx_full_pop", last_rd, 32'h200);
    step();
    rx_valid = 1'b0;
    cpu_read(2'd2);
    check_eq("rx_refill_count", 32'(last_rd[7:4]), 32'd8);
    check_eq("rx_refill_full", 32'(last_rd[11]), 32'd1);

    // Flush both while TX pops and RX pushes; rx_udf preserved
    cpu_read(2'd1);
    for (int i = 0; i < Depth; i++) cpu_read(2'd1);
    cpu_read(2'd1);
    cpu_write(2'd0, 32'hAA);
    cpu_write(2'd0, 32'hBB);
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 32'hCC;
    cpu_write(2'd3, 32'h3);
    tx_ready = 1'b0; rx_valid = 1'b0;
    cpu_read(2'd2);
    check_eq("flush_both", last_rd, 32'h0000_2500);
    cpu_write(2'd3, 32'h4);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      int op;
      tx_ready = ($urandom_range(0, 3) != 0);
      rx_valid = ($urandom_range(0, 2) != 0);
      rx_data  = $urandom;
      op = $urandom_range(0, 19);
      sel = 1'b1; data_in = $urandom;
      if (op < 6)       begin we = 1'b1; addr = 2'd0; end
      else if (op < 11) begin we = 1'b0; addr = 2'd1; end
      else if (op < 13) begin we = 1'b0; addr = 2'd2; end
      else if (op == 13) begin we = 1'b1; addr = 2'd3; data_in = 32'($urandom_range(0, 7)); end
      else if (op == 14) begin we = 1'b1; addr = 2'($urandom_range(1, 2)); end
      else if (op == 15) begin we = 1'b0; addr = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0; end
      else begin sel = 1'b0; we = $urandom_range(0, 1); addr = $urandom_range(0, 3); end
      step();
    end
    bus_idle();

    // Reset in the middle of traffic
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 32'h77;
    cpu_write(2'd0, 32'h66);
    async_reset();
    tx_ready = 1'b0; rx_valid = 1'b0;
    cpu_read(2'd2);
    check_eq("post_reset_status", last_rd, 32'h0000_0500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
